// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the multi-channel PWM generator: default parameter
// values, counting-mode encodings and the counter direction type.
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NUM_CH  = 3;
  localparam int DEF_PRESC_W = 8;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_prescaler.sv
// -----------------------------------------------------------------------------
// pwm_prescaler
// Divides clk into count ticks: one tick every prescale_i+1 cycles while
// enabled. The divide value is sampled live.
// Ports:
//   clk_i      system clock
//   rst_ni     synchronous reset, active-low
//   enable_i   1 = run, 0 = counter held at 0 and no ticks
//   prescale_i divide value
//   tick_o     1-cycle tick (combinational from the counter register)
// -----------------------------------------------------------------------------
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic [PRESC_W-1:0] prescale_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;

  always_comb begin
    tick_o      = enable_i && (presc_cnt_q == prescale_i);
    presc_cnt_d = presc_cnt_q + 1'b1;
    if (!enable_i || tick_o) begin
      presc_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      presc_cnt_q <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// -----------------------------------------------------------------------------
// pwm_multi
// Multi-channel PWM generator. One shared period counter (edge- or
// center-aligned, prescaled) feeds NUM_CH comparators. Period, mode and duty
// levels are double-buffered: update captures them into pending registers,
// and they are copied into the active (shadow) set only when the counter
// returns to 0, or immediately while disabled.
// Ports:
//   clk, reset (sync, active-low), enable
//   prescale       tick every prescale+1 cycles
//   period         pending counter top value
//   center_mode    pending mode (0 edge, 1 center)
//   level          pending duty levels, channel i = level[i*WIDTH +: WIDTH]
//   update         strobe capturing period/center_mode/level
//   invert         live per-channel output polarity
//   out            registered PWM outputs
//   period_start   registered pulse on the cycle the counter shows 0 at a boundary
//   update_pending captured values waiting for the next boundary
// -----------------------------------------------------------------------------
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [PRESC_W-1:0]      prescale,
  input  logic [WIDTH-1:0]        period,
  input  logic                    center_mode,
  input  logic [NUM_CH*WIDTH-1:0] level,
  input  logic                    update,
  input  logic [NUM_CH-1:0]       invert,
  output logic [NUM_CH-1:0]       out,
  output logic                    period_start,
  output logic                    update_pending
);

  logic tick;

  logic [WIDTH-1:0]        cnt_q, cnt_d;
  dir_e                    dir_q, dir_d;
  logic [WIDTH-1:0]        shadow_period_q, shadow_period_d;
  logic                    shadow_mode_q, shadow_mode_d;
  logic [NUM_CH*WIDTH-1:0] shadow_level_q, shadow_level_d;
  logic [WIDTH-1:0]        pend_period_q, pend_period_d;
  logic                    pend_mode_q, pend_mode_d;
  logic [NUM_CH*WIDTH-1:0] pend_level_q, pend_level_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [NUM_CH-1:0]       out_q, out_d;
  logic                    period_start_q, period_start_d;
  logic                    boundary;
  logic                    shadow_load;
  logic [NUM_CH-1:0]       cmp;

  pwm_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk_i      (clk),
    .rst_ni     (reset),
    .enable_i   (enable),
    .prescale_i (prescale),
    .tick_o     (tick)
  );

  // Counter and direction next state.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!enable) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (tick) begin
      if (shadow_mode_q == MODE_EDGE) begin
        cnt_d = (cnt_q >= shadow_period_q) ? '0 : cnt_q + 1'b1;
      end else if (shadow_period_q == '0) begin
        cnt_d = '0;
      end else if (dir_q == DIR_UP) begin
        // Turn around at the top: the top value is shown for one tick only.
        if (cnt_q >= shadow_period_q) begin
          cnt_d = cnt_q - 1'b1;
          dir_d = DIR_DOWN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
    boundary = tick && (cnt_d == '0);
    if (boundary) begin
      dir_d = DIR_UP;
    end
  end

  // Double-buffered configuration. A strobe coinciding with a load goes
  // straight to the shadow set so it is never delayed by a whole period.
  always_comb begin
    shadow_load     = boundary || !enable;
    shadow_period_d = shadow_period_q;
    shadow_mode_d   = shadow_mode_q;
    shadow_level_d  = shadow_level_q;
    pend_period_d   = pend_period_q;
    pend_mode_d     = pend_mode_q;
    pend_level_d    = pend_level_q;
    pend_valid_d    = pend_valid_q;
    if (update) begin
      pend_period_d = period;
      pend_mode_d   = center_mode;
      pend_level_d  = level;
    end
    if (shadow_load) begin
      if (update) begin
        shadow_period_d = period;
        shadow_mode_d   = center_mode;
        shadow_level_d  = level;
      end else if (pend_valid_q) begin
        shadow_period_d = pend_period_q;
        shadow_mode_d   = pend_mode_q;
        shadow_level_d  = pend_level_q;
      end
      pend_valid_d = 1'b0;
    end else if (update) begin
      pend_valid_d = 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign cmp[gi] = cnt_q < shadow_level_q[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Idle level while disabled is the inverted-low output, i.e. invert itself.
  assign out_d          = enable ? (cmp ^ invert) : invert;
  assign period_start_d = boundary;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q           <= '0;
      dir_q           <= DIR_UP;
      shadow_period_q <= '1;
      shadow_mode_q   <= MODE_EDGE;
      shadow_level_q  <= '0;
      pend_period_q   <= '1;
      pend_mode_q     <= MODE_EDGE;
      pend_level_q    <= '0;
      pend_valid_q    <= 1'b0;
      out_q           <= '0;
      period_start_q  <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      dir_q           <= dir_d;
      shadow_period_q <= shadow_period_d;
      shadow_mode_q   <= shadow_mode_d;
      shadow_level_q  <= shadow_level_d;
      pend_period_q   <= pend_period_d;
      pend_mode_q     <= pend_mode_d;
      pend_level_q    <= pend_level_d;
      pend_valid_q    <= pend_valid_d;
      out_q           <= out_d;
      period_start_q  <= period_start_d;
    end
  end

  assign out            = out_q;
  assign period_start   = period_start_q;
  assign update_pending = pend_valid_q;

endmodule

// File: tb/tb_pwm_multi.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi
// Directed bench for pwm_multi. Expected waveforms are written as strings read
// left to right, one character per clock cycle after the stimulus starts.
// -----------------------------------------------------------------------------
module tb_pwm_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  prescale;
  logic [7:0]  period;
  logic        center_mode;
  logic [23:0] level;
  logic        update;
  logic [2:0]  invert;
  logic [2:0]  out;
  logic        period_start;
  logic        update_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_multi #(
    .WIDTH   (8),
    .NUM_CH  (3),
    .PRESC_W (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .prescale       (prescale),
    .period         (period),
    .center_mode    (center_mode),
    .level          (level),
    .update         (update),
    .invert         (invert),
    .out            (out),
    .period_start   (period_start),
    .update_pending (update_pending)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic wbit(input string s, input int i);
    return s.getc(i) == 8'h31;
  endfunction

  task automatic do_reset();
    reset  = 1'b0;
    enable = 1'b0;
    update = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Load a configuration while disabled; it must go straight to the active set.
  task automatic load_cfg(input logic [7:0] pre, input logic [7:0] per,
                          input logic mode, input logic [23:0] lvl);
    prescale    = pre;
    period      = per;
    center_mode = mode;
    level       = lvl;
    update      = 1'b1;
    @(negedge clk);
    update = 1'b0;
    chk_eq("load_no_pending", 32'(update_pending), 32'd0);
  endtask

  // Run enabled for w0.len() cycles checking out, period_start, update_pending.
  // hi = expected constant value of out[2:1]; optional update strobe at
  // cycle upd_at; enable low for cycles [off_from, off_to).
  task automatic run_seq(input string name, input string w0, input string wps,
                         input string wup, input logic [1:0] hi, input int upd_at,
                         input logic [7:0] upd_lvl0, input logic [7:0] upd_per,
                         input int off_from, input int off_to);
    for (int i = 0; i < w0.len(); i++) begin
      update = (i == upd_at);
      if (i == upd_at) begin
        level[7:0] = upd_lvl0;
        period     = upd_per;
      end
      enable = !(i >= off_from && i < off_to);
      @(negedge clk);
      chk_eq($sformatf("%s out[%0d]", name, i), 32'(out), 32'({hi, wbit(w0, i)}));
      chk_eq($sformatf("%s pstart[%0d]", name, i), 32'(period_start), 32'(wbit(wps, i)));
      chk_eq($sformatf("%s upend[%0d]", name, i), 32'(update_pending), 32'(wbit(wup, i)));
    end
    update = 1'b0;
    $display("[tb] %s: %0d cycles checked", name, w0.len());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b0;
    enable      = 1'b1;
    prescale    = 8'd0;
    period      = 8'd0;
    center_mode = 1'b0;
    level       = 24'd0;
    update      = 1'b0;
    invert      = 3'b101;

    // Reset hold with enable high and inversion set: outputs stay at 0.
    repeat (3) @(negedge clk);
    chk_eq("rst out", 32'(out), 32'd0);
    chk_eq("rst pstart", 32'(period_start), 32'd0);
    chk_eq("rst upend", 32'(update_pending), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk_eq("rel out0", 32'(out), 32'h5);
    chk_eq("rel pstart", 32'(period_start), 32'd0);
    @(negedge clk);
    chk_eq("rel out1", 32'(out), 32'h5);
    $display("[tb] reset hold done");

    // Edge mode, period 4: ch0 level 2, ch1 level 0, ch2 level 7 (> top).
    invert = 3'b000;
    do_reset();
    load_cfg(8'd0, 8'd4, 1'b0, {8'd7, 8'd0, 8'd2});
    run_seq("edge", "1100011000", "0000100001", "0000000000", 2'b10, -1, 8'd0, 8'd0, -1, -1);

    // Center mode, period 4, ch0 level 2: high 3 of 8.
    do_reset();
    load_cfg(8'd0, 8'd4, 1'b1, {8'd0, 8'd0, 8'd2});
    run_seq("center", "1100000111000001", "0000000100000001", "0000000000000000",
            2'b00, -1, 8'd0, 8'd0, -1, -1);

    // Prescaler 2, edge, period 3, level 1: high 3 of 12 clk.
    do_reset();
    load_cfg(8'd2, 8'd3, 1'b0, {8'd0, 8'd0, 8'd1});
    run_seq("presc", "111000000000111000000000", "000000000001000000000001",
            "000000000000000000000000", 2'b00, -1, 8'd0, 8'd0, -1, -1);

    // Double buffering: mid-period update level 1->3, period 4->2.
    do_reset();
    load_cfg(8'd0, 8'd4, 1'b0, {8'd0, 8'd0, 8'd1});
    run_seq("dbuf", "10000111111", "00001001001", "00110000000", 2'b00, 2, 8'd3, 8'd2, -1, -1);

    // Update coinciding with a boundary applies at once, nothing pending.
    do_reset();
    load_cfg(8'd0, 8'd4, 1'b0, {8'd0, 8'd0, 8'd1});
    run_seq("coinc", "1000011100", "0000100001", "0000000000", 2'b00, 4, 8'd3, 8'd4, -1, -1);

    // Enable dropped mid-period: idle = invert, counter restarts at 0.
    invert = 3'b110;
    do_reset();
    load_cfg(8'd0, 8'd4, 1'b0, {8'd0, 8'd0, 8'd1});
    run_seq("endrop", "1000100001", "0000000010", "0000000000", 2'b11, -1, 8'd0, 8'd0, 2, 4);

    // Reset mid-period with an update pending: everything back to reset values.
    level[7:0] = 8'd3;
    period     = 8'd4;
    update     = 1'b1;
    @(negedge clk);
    update = 1'b0;
    chk_eq("midrst pend", 32'(update_pending), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk_eq("midrst out", 32'(out), 32'd0);
    chk_eq("midrst pstart", 32'(period_start), 32'd0);
    chk_eq("midrst upend", 32'(update_pending), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk_eq("postrst out0", 32'(out), 32'h6);
    @(negedge clk);
    chk_eq("postrst out1", 32'(out), 32'h6);
    chk_eq("postrst upend", 32'(update_pending), 32'd0);
    $display("[tb] mid-period reset done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
